// File: rtl/turbo_deinterleaver.sv
// Bit-serial QPP turbo deinterleaver for K=1056/6144: scatters interleaved bits into a
// 6144-bit buffer at pi(i), then drains the block as MSB-first bytes with valid/ready.
module turbo_deinterleaver (
    input  logic       clock,
    input  logic       rst,
    input  logic       k_size_6144,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       block_done
);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    state_e        state_q, state_d;
    logic          k6144_q, k6144_d;
    logic [12:0]   i_q, i_d;
    logic [12:0]   pi_q, pi_d;
    logic [12:0]   g_q, g_d;
    logic [9:0]    n_q, n_d;
    logic          done_q, done_d;
    logic          buf_we;
    logic [6143:0] buf_q;

    logic [12:0]   k_val;
    logic [12:0]   g_step;
    logic [9:0]    n_last;

    assign k_val  = k6144_q ? 13'd6144 : 13'd1056;
    assign g_step = k6144_q ? 13'd960  : 13'd132;
    assign n_last = k6144_q ? 10'd767  : 10'd131;

    // Operands are already reduced below k, so one conditional subtract suffices.
    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[12:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k6144_d = k6144_q;
        i_d     = i_q;
        pi_d    = pi_q;
        g_d     = g_q;
        n_d     = n_q;
        done_d  = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    k6144_d = k_size_6144;
                    i_d     = '0;
                    pi_d    = '0;
                    g_d     = k_size_6144 ? 13'd743 : 13'd83;
                    n_d     = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (bit_valid) begin
                    buf_we = 1'b1;
                    pi_d   = mod_add(pi_q, g_q, k_val);
                    g_d    = mod_add(g_q, g_step, k_val);
                    i_d    = i_q + 13'd1;
                    if (i_q == k_val - 13'd1) begin
                        i_d     = '0;
                        n_d     = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (byte_ready) begin
                    if (n_q == n_last) begin
                        n_d     = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        n_d = n_q + 10'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            k6144_q <= 1'b0;
            i_q     <= '0;
            pi_q    <= '0;
            g_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k6144_q <= k6144_d;
            i_q     <= i_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    // Buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_q[pi_q] <= bit_in;
        end
    end

    always_comb begin
        byte_out = 8'h00;
        if (state_q == StDrain) begin
            for (int j = 0; j < 8; j++) begin
                byte_out[7-j] = buf_q[{n_q, 3'(j)}];
            end
        end
    end

    assign byte_valid = (state_q == StDrain);
    assign busy       = (state_q != StIdle);
    assign block_done = done_q;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Scoreboard bench for turbo_deinterleaver: the driver pushes expected bytes computed from the
// QPP formula pi(i) = (f1*i + f2*i*i) mod K; a negedge monitor pops and compares on handshakes.
module tb_turbo_deinterleaver;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       k_size_6144 = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       block_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         size_q[$];
    bit         cblk[0:6143];
    bit         strm[0:6143];
    bit         rnd_ready = 1'b0;
    bit         noise = 1'b0;
    int         gap_pct = 0;

    turbo_deinterleaver dut (
        .clock      (clock),
        .rst        (rst),
        .k_size_6144(k_size_6144),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int qpp(input int k, input int i);
        longint f1, f2, li;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    // Random block c; the serial stream is c(pi(i)); expected output is c packed MSB first.
    task automatic build_random(input int k);
        logic [7:0] b;
        for (int p = 0; p < k; p++) cblk[p] = 1'($urandom % 2);
        for (int i = 0; i < k; i++) strm[i] = cblk[qpp(k, i)];
        for (int n = 0; n < k / 8; n++) begin
            for (int j = 0; j < 8; j++) b[7-j] = cblk[8*n+j];
            exp_q.push_back(b);
        end
        size_q.push_back(k / 8);
    endtask

    task automatic build_single(input int k, input int pos, input int hot_byte,
                                input logic [7:0] hot_val);
        for (int i = 0; i < k; i++) strm[i] = 1'b0;
        strm[pos] = 1'b1;
        for (int n = 0; n < k / 8; n++) exp_q.push_back((n == hot_byte) ? hot_val : 8'h00);
        size_q.push_back(k / 8);
    endtask

    task automatic do_noise();
        if (noise) begin
            start       = 1'($urandom % 2);
            k_size_6144 = 1'($urandom % 2);
        end
    endtask

    // Entered at posedge+1 with the DUT idle; start is issued in the current cycle.
    task automatic run_block(input int k, input int abort_at, input bit lat_chk);
        k_size_6144 = (k == 6144);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (i == abort_at) begin
                bit_valid = 1'b0;
                start = 1'b0;
                rst = 1'b1;
                @(posedge clock); #1;
                rst = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_byte_valid", byte_valid, 0);
                check("abort_block_done", block_done, 0);
                return;
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bit_valid = 1'b0;
                bit_in = 1'($urandom % 2);
                do_noise();
                @(posedge clock); #1;
            end
            bit_valid = 1'b1;
            bit_in = strm[i];
            do_noise();
            if (lat_chk && i == k - 1) check("no_valid_before_last_bit", byte_valid, 0);
            @(posedge clock); #1;
        end
        bit_valid = 1'b0;
        start = 1'b0;
        if (lat_chk) check("first_valid_at_k_plus_1", byte_valid, 1);
    endtask

    // Returns at posedge+1 of the block_done cycle, the first cycle a new start is taken.
    task automatic wait_done();
        for (int c = 0; c < 20000; c++) begin
            if (block_done) begin
                start = 1'b0;
                bit_valid = 1'b0;
                check("idle_on_done", busy, 0);
                return;
            end
            if (noise) begin
                bit_valid = 1'($urandom % 2);
                bit_in = 1'($urandom % 2);
            end
            do_noise();
            @(posedge clock); #1;
        end
        start = 1'b0;
        bit_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL block_done_timeout: got none expected pulse within 20000 cycles");
    endtask

    initial begin
        forever begin
            @(posedge clock); #1;
            byte_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    logic [7:0] prev_byte = 8'h00;
    bit         prev_stall = 1'b0;
    int         hs = 0;

    always @(negedge clock) begin
        if (rst) begin
            prev_stall = 1'b0;
            hs = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", byte_valid, 1);
                check("stall_byte_stable", byte_out, prev_byte);
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", byte_out);
                end else begin
                    check("byte", byte_out, exp_q.pop_front());
                end
                hs++;
            end
            if (block_done) begin
                if (size_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block_done: got pulse expected none");
                end else begin
                    check("handshakes_per_block", hs, size_q.pop_front());
                end
                hs = 0;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte = byte_out;
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_byte_valid", byte_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_block_done", block_done, 0);
        check("reset_byte_out", byte_out, 0);
        rst = 1'b0;
        // Idle ignores bits without start.
        bit_valid = 1'b1;
        bit_in = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        bit_valid = 1'b0;
        check("idle_ignores_bits", busy, 0);

        // K=1056, 1 at i=1 -> pi=83 -> byte 10 = 8'h10.
        build_single(1056, 1, 10, 8'h10);
        run_block(1056, -1, 1'b1);
        wait_done();
        @(posedge clock); #1;

        // K=6144, 1 at i=2 -> pi=2446 -> byte 305 = 8'h02.
        build_single(6144, 2, 305, 8'h02);
        run_block(6144, -1, 1'b1);
        wait_done();

        // Back-to-back: start issued in the block_done cycle.
        gap_pct = 30;
        build_random(1056);
        run_block(1056, -1, 1'b0);
        wait_done();

        // Random stalls plus ignored start/bit_valid/k_size noise during COLLECT and DRAIN.
        rnd_ready = 1'b1;
        noise = 1'b1;
        gap_pct = 20;
        build_random(1056);
        run_block(1056, -1, 1'b0);
        wait_done();

        // Abort at i=500 by reset, then a full K=6144 block.
        noise = 1'b0;
        gap_pct = 10;
        @(posedge clock); #1;
        run_block(1056, 500, 1'b0);
        build_random(6144);
        run_block(6144, -1, 1'b0);
        wait_done();

        repeat (5) begin @(posedge clock); #1; end
        check("all_bytes_consumed", exp_q.size(), 0);
        check("all_blocks_done", size_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turbo_deinterleaver.md
TURBO_DEINTERLEAVER -- requirements
Module: turbo_deinterleaver

Interface
REQ-001 Parameters: none; block sizes K=1056 and K=6144 are fixed, and their QPP coefficients are hard-coded: (f1,f2)=(17,66) and (263,480).
REQ-002 clock  input  1  single clock for all logic, rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 k_size_6144  input  1  block size select: 0=1056, 1=6144; sampled only on an accepted start.
REQ-005 start  input  1  one-cycle request to begin a new block; accepted only in IDLE.
REQ-006 bit_in  input  1  bit-serial interleaved data c'(i) = c(pi(i)), sent in increasing i.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 byte_out  output  8  deinterleaved data byte.
REQ-009 byte_valid  output  1  byte_out is valid.
REQ-010 byte_ready  input  1  downstream accepts byte_out when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-011 busy  output  1  high in COLLECT and DRAIN.
REQ-012 block_done  output  1  one-cycle pulse after the last byte of a block is accepted.

Function
REQ-013 States SHALL be IDLE, COLLECT and DRAIN; reset state is IDLE.
REQ-014 IDLE with start=1: latch K; clear i and pi to 0; set g=(f1+f2) mod K (83 or 743); enter COLLECT next cycle.
REQ-015 IDLE: start=0 stays in IDLE; bit_valid and bit_in are ignored.
REQ-016 COLLECT with bit_valid=1: store bit_in at block position pi; pi <= (pi+g) mod K; g <= (g + 2*f2 mod K) mod K, step 132 or 960; i <= i+1.
REQ-017 COLLECT with bit_valid=0: no state change; gaps of any length are legal.
REQ-018 Modular adds use 13-bit operands below K; if sum >= K, subtract K once; no multipliers or dividers.
REQ-019 After the K-th valid bit (i=K-1) is stored, go to DRAIN on the next cycle with byte index n=0.
REQ-020 DRAIN: byte_valid=1; byte_out = block bits 8n..8n+7, with bit 8n on byte_out[7] (MSB first).
REQ-021 DRAIN: byte_out and byte_valid stay stable while byte_ready=0; on handshake n <= n+1.
REQ-022 DRAIN: sustain one byte per cycle while byte_ready=1; a block emits 132 or 768 bytes.
REQ-023 Handshake on the last byte (n=K/8-1): byte_valid=0 and block_done=1 next cycle; return to IDLE the same cycle.
REQ-024 start during COLLECT or DRAIN is ignored; k_size_6144 changes mid-block have no effect.
REQ-025 bit_valid during DRAIN is ignored; input bits are dropped.
REQ-026 The earliest next start is accepted in the cycle block_done=1; that is the first IDLE cycle.
REQ-027 Storage SHALL be one 6144-bit buffer; K=1056 uses positions 0..1055 only.
REQ-028 Latency from start accepted to first byte_valid = K + 1 cycles, with bit_valid held high.

Reset
REQ-029 With rst=1 at an edge: state=IDLE, byte_valid=0, busy=0, block_done=0, byte_out=8'h00, i=pi=n=0.
REQ-030 Reset mid-COLLECT or mid-DRAIN aborts the block with no block_done; buffer contents are don't-care.
REQ-031 rst has priority over start, bit_valid and byte_ready in the same cycle.

Verification
REQ-032 K=1056; drive 1056 bits with bit_in=1 only at i=1 -> bit 83 set -> byte 10 = 8'h10, all other 131 bytes = 8'h00, then block_done.
REQ-033 K=6144; check pi values -> pi(1)=743, pi(2)=2446; single 1 at i=2 -> byte 305 = 8'h02.
REQ-034 K=1056; random block c; reference model sends c(pi(i)) with random bit_valid gaps -> output bytes equal c packed MSB first.
REQ-035 DRAIN with byte_ready toggling randomly -> byte_out stable while stalled, no lost or duplicated bytes, exactly 132 handshakes.
REQ-036 rst pulsed at i=500 of COLLECT, then new start with K=6144 -> full correct 768-byte block; no block_done for the aborted block.
REQ-037 start pulsed during COLLECT and DRAIN, bit_valid during DRAIN -> no effect; back-to-back blocks with start on the block_done cycle -> accepted.
